// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// State encodings are fixed so later serial units can share them.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single gate-level full-subtractor cell: diff = a ^ b ^ bin, with borrow out.
module full_subtractor (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// One full_subtractor cell plus a borrow flop replaces the N-cell ripple chain.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  res_sr;
    logic          br;
    logic [CW-1:0] cnt;

    logic          d;
    logic          br_next;
    logic          load;
    logic          shift;
    logic          last_bit;

    full_subtractor u_fs (
        .diff (d),
        .bout (br_next),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start)    state_next = RUN;
            RUN:  if (last_bit) state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    always_comb begin
        load     = (state == IDLE) && start;
        shift    = (state == RUN);
        last_bit = shift && (cnt == LAST);
    end

    // NOTE: the operand/result shift registers are plain flops, so they are reset
    // with everything else; an abort leaves no stale bits behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= last_bit;
            if (load) begin
                a_sr   <= a;
                b_sr   <= b;
                res_sr <= '0;
                br     <= borrow_in;
                cnt    <= '0;
            end else if (shift) begin
                a_sr   <= {1'b0, a_sr[N-1:1]};
                b_sr   <= {1'b0, b_sr[N-1:1]};
                res_sr <= {d, res_sr[N-1:1]};
                br     <= br_next;
                cnt    <= last_bit ? '0 : cnt + 1'b1;
            end
            // Outputs only move at completion, never mid-operation.
            if (last_bit) begin
                diff       <= {d, res_sr[N-1:1]};
                borrow_out <= br_next;
            end
        end
    end

    assign busy = (state == RUN);

endmodule
